// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key width, key codes and press-detector state encoding.
package keypad_pkg;

    localparam int KEY_W = 5;

    localparam logic [KEY_W-1:0] KEY_CLR  = 5'h0A;
    localparam logic [KEY_W-1:0] KEY_BSP  = 5'h0B;
    localparam logic [KEY_W-1:0] KEY_NEXT = 5'h0C;
    localparam logic [KEY_W-1:0] KEY_NONE = 5'h1F;

    typedef enum logic {
        WAIT_PRESS   = 1'b0,
        WAIT_RELEASE = 1'b1
    } press_state_e;

    // Digit codes are 0..9; everything else is a command or ignored.
    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return (k <= 5'd9);
    endfunction

endpackage

// File: rtl/keypad_operand_bank_if.sv
// Keypad operand bank bus: key/control inputs toward the bank, operand state back out.
interface keypad_operand_bank_if #(
    parameter int DIGITS   = 4,
    parameter int OPERANDS = 2
);
    import keypad_pkg::*;

    localparam int VW = 4 * DIGITS;
    localparam int SW = $clog2(OPERANDS);
    localparam int CW = $clog2(DIGITS + 1);

    logic [KEY_W-1:0]         key;
    logic                     en;
    logic                     load;
    logic [SW-1:0]            load_idx;
    logic [VW-1:0]            load_val;
    logic [VW*OPERANDS-1:0]   ops;
    logic [SW-1:0]            sel;
    logic [CW-1:0]            cnt;
    logic                     full;
    logic                     evt;
    logic                     err;

    // Controller side: drives keys, enable and load strobes.
    modport master (
        output key, en, load, load_idx, load_val,
        input  ops, sel, cnt, full, evt, err
    );

    // Operand bank side.
    modport slave (
        input  key, en, load, load_idx, load_val,
        output ops, sel, cnt, full, evt, err
    );

endinterface

// File: rtl/kob_key_event.sv
// Key press detector: one event per press, key held through reset stays silent.
// Optional auto-repeat of digits and backspace when KOB_AUTOREPEAT_EN is defined.
module kob_key_event
    import keypad_pkg::*;
#(
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    output logic             evt_o,
    output logic [KEY_W-1:0] code_o
);

    // Repeat timing must allow the counter to be rewound by REPEAT_RATE.
    if (REPEAT_RATE < 1 || REPEAT_DLY < REPEAT_RATE) begin : g_bad_cfg
        $error("kob_key_event: need 1 <= REPEAT_RATE <= REPEAT_DLY");
    end

    press_state_e state_q, state_d;

`ifdef KOB_AUTOREPEAT_EN
    localparam int HW = $clog2(REPEAT_DLY + 1);

    logic [HW-1:0]    hold_q, hold_d;
    logic [KEY_W-1:0] code_q, code_d;

    // Press detection plus hold counter; repeats reuse the code captured at the press.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        code_d  = code_q;
        evt_o   = 1'b0;
        code_o  = key;
        case (state_q)
            WAIT_PRESS: begin
                hold_d = '0;
                if (key != KEY_NONE) begin
                    state_d = WAIT_RELEASE;
                    code_d  = key;
                    evt_o   = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (key == KEY_NONE) begin
                    state_d = WAIT_PRESS;
                    hold_d  = '0;
                end else if (hold_q == HW'(REPEAT_DLY - 1)) begin
                    // Rewind so the next repeat lands REPEAT_RATE cycles later.
                    hold_d = HW'(REPEAT_DLY - REPEAT_RATE);
                    code_o = code_q;
                    evt_o  = is_digit(code_q) || (code_q == KEY_BSP);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = WAIT_RELEASE;
        endcase
    end

    // State, hold counter and captured code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_RELEASE;
            hold_q  <= '0;
            code_q  <= KEY_NONE;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            code_q  <= code_d;
        end
    end
`else
    // Press detection: event only on the WAIT_PRESS -> WAIT_RELEASE transition.
    always_comb begin
        state_d = state_q;
        evt_o   = 1'b0;
        code_o  = key;
        case (state_q)
            WAIT_PRESS: begin
                if (key != KEY_NONE) begin
                    state_d = WAIT_RELEASE;
                    evt_o   = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (key == KEY_NONE) state_d = WAIT_PRESS;
            end
            default: state_d = WAIT_RELEASE;
        endcase
    end

    // State register; reset parks in WAIT_RELEASE so a held key must be released first.
    always_ff @(posedge clk) begin
        if (rst) state_q <= WAIT_RELEASE;
        else     state_q <= state_d;
    end
`endif

endmodule

// File: rtl/keypad_operand_bank.sv
// Keypad operand bank: BCD operand registers edited by key events, with
// per-operand digit counts, operand select and a result-load port.
// Optional build macro: KOB_AUTOREPEAT_EN (auto-repeat of held digits/backspace).
module keypad_operand_bank
    import keypad_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int OPERANDS    = 2,
    parameter int REPEAT_DLY  = 50,
    parameter int REPEAT_RATE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_operand_bank_if.slave  bus
);

    localparam int VW = 4 * DIGITS;
    localparam int SW = $clog2(OPERANDS);
    localparam int CW = $clog2(DIGITS + 1);

    if (DIGITS < 1 || DIGITS > 8 || OPERANDS < 2 || OPERANDS > 8) begin : g_bad_cfg
        $error("keypad_operand_bank: DIGITS must be 1..8, OPERANDS 2..8");
    end

    logic [OPERANDS-1:0][VW-1:0] ops_q, ops_d;
    logic [OPERANDS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0]               sel_q, sel_d;
    logic                        evt_q, evt_d;
    logic                        err_q, err_d;

    logic             kev;
    logic [KEY_W-1:0] kcode;
    logic [VW-1:0]    cur_op;
    logic [VW-1:0]    shl_op;
    logic [CW-1:0]    cur_cnt;

    kob_key_event #(
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_key_event (
        .clk    (clk),
        .rst    (rst),
        .key    (bus.key),
        .evt_o  (kev),
        .code_o (kcode)
    );

    // Significant digit count of a loaded value: highest non-zero nibble index + 1.
    function automatic logic [CW-1:0] sig_digits(input logic [VW-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] != 4'h0) n = CW'(i + 1);
        return n;
    endfunction

    // Next-state for operands, counts, select and the evt/err pulses.
    always_comb begin
        ops_d   = ops_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        evt_d   = 1'b0;
        err_d   = 1'b0;
        cur_op  = ops_q[sel_q];
        cur_cnt = cnt_q[sel_q];
        shl_op  = cur_op << 4;
        shl_op[3:0] = kcode[3:0];

        if (bus.load) begin
            // A load wins over any key event on the same edge; the event is dropped.
            if (int'(bus.load_idx) < OPERANDS) begin
                ops_d[bus.load_idx] = bus.load_val;
                cnt_d[bus.load_idx] = sig_digits(bus.load_val);
            end
        end else if (bus.en && kev) begin
            if (is_digit(kcode)) begin
                if (cur_cnt == CW'(DIGITS)) begin
                    err_d = 1'b1;
                end else if (cur_cnt == '0 && kcode == 5'd0) begin
                    // Leading zero: acknowledged but nothing stored.
                    evt_d = 1'b1;
                end else begin
                    ops_d[sel_q] = shl_op;
                    cnt_d[sel_q] = cur_cnt + CW'(1);
                    evt_d        = 1'b1;
                end
            end else begin
                case (kcode)
                    KEY_CLR: begin
                        ops_d[sel_q] = '0;
                        cnt_d[sel_q] = '0;
                        evt_d        = 1'b1;
                    end
                    KEY_BSP: begin
                        if (cur_cnt != '0) begin
                            ops_d[sel_q] = cur_op >> 4;
                            cnt_d[sel_q] = cur_cnt - CW'(1);
                            evt_d        = 1'b1;
                        end
                    end
                    KEY_NEXT: begin
                        sel_d = (sel_q == SW'(OPERANDS - 1)) ? '0 : sel_q + SW'(1);
                        evt_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bank registers; reset overrides load and key activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q <= '0;
            cnt_q <= '0;
            sel_q <= '0;
            evt_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ops_q <= ops_d;
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            evt_q <= evt_d;
            err_q <= err_d;
        end
    end

    assign bus.ops  = ops_q;
    assign bus.sel  = sel_q;
    assign bus.cnt  = cnt_q[sel_q];
    assign bus.full = (cnt_q[sel_q] == CW'(DIGITS));
    assign bus.evt  = evt_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_keypad_operand_bank.sv
// Directed bench for keypad_operand_bank (DIGITS=4, OPERANDS=2).
module tb_keypad_operand_bank;
    import keypad_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    keypad_operand_bank_if #(.DIGITS(4), .OPERANDS(2)) bus();

    keypad_operand_bank #(
        .DIGITS(4), .OPERANDS(2), .REPEAT_DLY(50), .REPEAT_RATE(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press and release; returns pulses seen after the press edge.
    task automatic press(input logic [4:0] k, output logic e, output logic r);
        bus.key = k;
        tick();
        e = bus.evt;
        r = bus.err;
        bus.key = KEY_NONE;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.key = KEY_NONE; bus.en = 1'b1; bus.load = 1'b0;
        bus.load_idx = '0; bus.load_val = '0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (bus.ops !== 32'h0 || bus.sel !== 1'b0 || bus.cnt !== 3'd0 ||
            bus.evt !== 1'b0 || bus.err !== 1'b0 || bus.full !== 1'b0) begin
            failures++;
            $display("FAIL reset: ops=%h sel=%0d cnt=%0d evt=%b err=%b full=%b want all 0",
                     bus.ops, bus.sel, bus.cnt, bus.evt, bus.err, bus.full);
        end
        tick(); // release seen, FSM back in WAIT_PRESS
    endtask

    task automatic test_digits();
        logic e, r;
        int n = 0;
        press(5'd1, e, r); n += int'(e);
        press(5'd2, e, r); n += int'(e);
        press(5'd3, e, r); n += int'(e);
        checks++;
        if (n != 3 || bus.ops[15:0] !== 16'h0123 || bus.cnt !== 3'd3) begin
            failures++;
            $display("FAIL digits: evts=%0d ops0=%h cnt=%0d want 3 0123 3", n, bus.ops[15:0], bus.cnt);
        end
`ifndef KOB_AUTOREPEAT_EN
        n = 0;
        bus.key = 5'd5;
        for (int i = 0; i < 100; i++) begin
            tick();
            n += int'(bus.evt);
        end
        bus.key = KEY_NONE;
        tick();
        checks++;
        if (n != 1 || bus.ops[15:0] !== 16'h1235 || bus.full !== 1'b1) begin
            failures++;
            $display("FAIL hold: evts=%0d ops0=%h full=%b want 1 1235 1", n, bus.ops[15:0], bus.full);
        end
`endif
    endtask

    task automatic test_full();
        logic e, r;
        bus.load = 1'b1; bus.load_idx = 1'b0; bus.load_val = 16'h1234;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.ops[15:0] !== 16'h1234 || bus.cnt !== 3'd4 || bus.full !== 1'b1) begin
            failures++;
            $display("FAIL load_full: ops0=%h cnt=%0d full=%b want 1234 4 1", bus.ops[15:0], bus.cnt, bus.full);
        end
        bus.key = 5'd7;
        tick();
        e = bus.evt; r = bus.err;
        tick();
        checks++;
        if (r !== 1'b1 || e !== 1'b0 || bus.err !== 1'b0 || bus.ops[15:0] !== 16'h1234 || bus.full !== 1'b1) begin
            failures++;
            $display("FAIL full_err: err=%b evt=%b err_next=%b ops0=%h full=%b want 1 0 0 1234 1",
                     r, e, bus.err, bus.ops[15:0], bus.full);
        end
        bus.key = KEY_NONE;
        tick();
        press(KEY_BSP, e, r);
        checks++;
        if (e !== 1'b1 || bus.ops[15:0] !== 16'h0123 || bus.cnt !== 3'd3 || bus.full !== 1'b0) begin
            failures++;
            $display("FAIL bsp: evt=%b ops0=%h cnt=%0d full=%b want 1 0123 3 0", e, bus.ops[15:0], bus.cnt, bus.full);
        end
        press(KEY_CLR, e, r);
        checks++;
        if (e !== 1'b1 || bus.ops[15:0] !== 16'h0 || bus.cnt !== 3'd0) begin
            failures++;
            $display("FAIL clr: evt=%b ops0=%h cnt=%0d want 1 0000 0", e, bus.ops[15:0], bus.cnt);
        end
        press(KEY_BSP, e, r);
        checks++;
        if (e !== 1'b0 || r !== 1'b0 || bus.ops[15:0] !== 16'h0 || bus.cnt !== 3'd0) begin
            failures++;
            $display("FAIL bsp_empty: evt=%b err=%b ops0=%h cnt=%0d want 0 0 0000 0", e, r, bus.ops[15:0], bus.cnt);
        end
    endtask

    task automatic test_select();
        logic e, r;
        press(KEY_NEXT, e, r);
        checks++;
        if (e !== 1'b1 || bus.sel !== 1'b1) begin
            failures++;
            $display("FAIL next1: evt=%b sel=%0d want 1 1", e, bus.sel);
        end
        press(KEY_NEXT, e, r);
        checks++;
        if (e !== 1'b1 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL next_wrap: evt=%b sel=%0d want 1 0", e, bus.sel);
        end
        press(5'd0, e, r);
        checks++;
        if (e !== 1'b1 || bus.ops[15:0] !== 16'h0 || bus.cnt !== 3'd0) begin
            failures++;
            $display("FAIL lead_zero: evt=%b ops0=%h cnt=%0d want 1 0000 0", e, bus.ops[15:0], bus.cnt);
        end
    endtask

    task automatic test_load_collision();
        logic e, r;
        bus.load = 1'b1; bus.load_idx = 1'b1; bus.load_val = 16'h0042;
        bus.key = 5'd4;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.evt !== 1'b0 || bus.err !== 1'b0 || bus.ops[31:16] !== 16'h0042 ||
            bus.ops[15:0] !== 16'h0 || bus.sel !== 1'b0) begin
            failures++;
            $display("FAIL load_coll: evt=%b err=%b ops1=%h ops0=%h sel=%0d want 0 0 0042 0000 0",
                     bus.evt, bus.err, bus.ops[31:16], bus.ops[15:0], bus.sel);
        end
        bus.key = KEY_NONE;
        tick();
        press(KEY_NEXT, e, r);
        checks++;
        if (bus.sel !== 1'b1 || bus.cnt !== 3'd2) begin
            failures++;
            $display("FAIL load_cnt: sel=%0d cnt=%0d want 1 2", bus.sel, bus.cnt);
        end
        press(KEY_NEXT, e, r);
        // Nibble above 9 stored as-is; count follows the highest non-zero nibble.
        bus.load = 1'b1; bus.load_idx = 1'b0; bus.load_val = 16'h00A0;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.ops[15:0] !== 16'h00A0 || bus.cnt !== 3'd2) begin
            failures++;
            $display("FAIL load_hex: ops0=%h cnt=%0d want 00a0 2", bus.ops[15:0], bus.cnt);
        end
        press(KEY_CLR, e, r);
    endtask

    task automatic test_reset_held();
        logic e, r;
        bus.key = 5'd3;
        rst = 1'b1;
        bus.load = 1'b1; bus.load_idx = 1'b0; bus.load_val = 16'h9999;
        tick();
        rst = 1'b0;
        bus.load = 1'b0;
        checks++;
        if (bus.ops !== 32'h0 || bus.evt !== 1'b0) begin
            failures++;
            $display("FAIL reset_prio: ops=%h evt=%b want 0 0", bus.ops, bus.evt);
        end
        tick(); tick();
        checks++;
        if (bus.evt !== 1'b0 || bus.ops[15:0] !== 16'h0) begin
            failures++;
            $display("FAIL reset_held: evt=%b ops0=%h want 0 0000", bus.evt, bus.ops[15:0]);
        end
        bus.key = KEY_NONE;
        tick();
        press(5'd3, e, r);
        checks++;
        if (e !== 1'b1 || bus.ops[15:0] !== 16'h0003 || bus.cnt !== 3'd1) begin
            failures++;
            $display("FAIL repress: evt=%b ops0=%h cnt=%0d want 1 0003 1", e, bus.ops[15:0], bus.cnt);
        end
    endtask

    task automatic test_enable();
        logic e, r;
        bus.en = 1'b0;
        press(5'd9, e, r);
        checks++;
        if (e !== 1'b0 || r !== 1'b0 || bus.ops[15:0] !== 16'h0003 || bus.cnt !== 3'd1) begin
            failures++;
            $display("FAIL en_off: evt=%b err=%b ops0=%h cnt=%0d want 0 0 0003 1", e, r, bus.ops[15:0], bus.cnt);
        end
        bus.en = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic e, r;
        int n = 0;
        // Rolling from one key to another without release is still one press.
        bus.key = 5'd1; tick(); n += int'(bus.evt);
        bus.key = 5'd2; tick(); n += int'(bus.evt);
        bus.key = KEY_NONE; tick();
        press(5'd4, e, r); n += int'(e);
        checks++;
        if (n != 2 || bus.ops[15:0] !== 16'h0314) begin
            failures++;
            $display("FAIL roll: evts=%0d ops0=%h want 2 0314", n, bus.ops[15:0]);
        end
        press(KEY_CLR, e, r);
    endtask

`ifdef KOB_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int n = 0;
        int second = -1;
        bus.key = 5'd8;
        for (int i = 0; i < 75; i++) begin
            tick();
            if (bus.evt) begin
                if (n == 1) second = i;
                n++;
            end
        end
        bus.key = KEY_NONE;
        tick();
        checks++;
        if (n != 4 || second != 50 || bus.ops[15:0] !== 16'h8888) begin
            failures++;
            $display("FAIL autorepeat: evts=%0d first_rep=%0d ops0=%h want 4 50 8888", n, second, bus.ops[15:0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_digits();
        test_full();
        test_select();
        test_load_collision();
        test_reset_held();
        test_enable();
        test_back_to_back();
`ifdef KOB_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
